// File: rtl/fixlat_credit_collector.sv
// fixlat_credit_collector
//   Collects words emerging from a fixed-latency, non-stallable payload pipe
//   into a small circular FIFO and presents them on a valid/ready output.
//   Since the pipe cannot be back-pressured, the block also produces the
//   upstream issue-ready by tracking outstanding words (in flight + stored),
//   so the FIFO cannot overflow as long as upstream honours issue_ready_o.
//
// Ports
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   issue_valid_i       upstream wants to launch a word into the pipe
//   issue_ready_o       launch allowed this cycle (credit available)
//   pipe_valid_i/data_i word arriving at the pipe output
//   out_valid_o/data_o  FIFO head; out_ready_i accepts it
//   flush_i             discard stored words (in-flight words still land)
//   usage_o             words currently stored
//   error_o             sticky: spurious arrival or overflow
module fixlat_credit_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic                  pipe_valid_i,
    input  logic [DATA_WIDTH-1:0] pipe_data_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  out_ready_i,
    input  logic                  flush_i,
    output logic [CNT_W-1:0]      usage_o,
    output logic                  error_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      usage_q, usage_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [CNT_W-1:0]      outst_q, outst_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  error_q, error_d;
    logic                  issue, push, pop, spurious, overflow, push_acc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign issue_ready_o = (outst_q < DEPTH_C);
    assign out_valid_o   = (usage_q != '0);
    assign out_data_o    = head_q;
    assign usage_o       = usage_q;
    assign error_o       = error_q;

    always_comb begin
        issue    = issue_valid_i & issue_ready_o;
        push     = pipe_valid_i;
        pop      = out_valid_o & out_ready_i;
        spurious = push & (inflight_q == '0);
        overflow = push & (usage_q == DEPTH_C) & ~pop;
        push_acc = push & ~spurious & ~overflow;
        error_d  = error_q | spurious | overflow;

        // A spurious arrival has no matching issue, so it does not consume one.
        inflight_d = inflight_q;
        if (issue && !(push && inflight_q != '0)) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue && push && inflight_q != '0) begin
            inflight_d = inflight_q - 1'b1;
        end

        wr_ptr_d = push_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;

        if (flush_i) begin
            // A same-cycle arrival survives the flush as the only stored word.
            rd_ptr_d = wr_ptr_q;
            usage_d  = CNT_W'(push_acc);
            outst_d  = inflight_d + CNT_W'(push_acc);
        end else begin
            rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            usage_d  = usage_q + CNT_W'(push_acc) - CNT_W'(pop);
            outst_d  = outst_q;
            if (issue && !pop) begin
                outst_d = outst_q + 1'b1;
            end else if (!issue && pop && outst_q != '0) begin
                outst_d = outst_q - 1'b1;
            end
        end

        // Registered head copy: no fall-through, and the value holds while
        // the FIFO is empty (including across a flush that moves rd_ptr).
        head_d = head_q;
        if (usage_d != '0) begin
            if (push_acc && rd_ptr_d == wr_ptr_q) begin
                head_d = pipe_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            usage_q    <= '0;
            inflight_q <= '0;
            outst_q    <= '0;
            head_q     <= '0;
            error_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            usage_q    <= usage_d;
            inflight_q <= inflight_d;
            outst_q    <= outst_d;
            head_q     <= head_d;
            error_q    <= error_d;
            if (push_acc) begin
                mem_q[wr_ptr_q] <= pipe_data_i;
            end
        end
    end

endmodule

// File: tb/tb_fixlat_credit_collector.sv
// tb_fixlat_credit_collector
//   Drives fixlat_credit_collector through a 2-cycle pipe model. A directed
//   table covers reset, fill to credit limit, drain with pointer wrap,
//   steady-state streaming, flush (with and without a same-cycle arrival)
//   and the spurious-arrival error. A randomized phase follows, checked
//   against a queue-based reference model.
module tb_fixlat_credit_collector;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          issue_valid_i = 1'b0;
    logic          issue_ready_o;
    logic          pipe_valid_i = 1'b0;
    logic [DW-1:0] pipe_data_i = '0;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [CW-1:0] usage_o;
    logic          error_o;

    fixlat_credit_collector #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .issue_valid_i(issue_valid_i),
        .issue_ready_o(issue_ready_o),
        .pipe_valid_i (pipe_valid_i),
        .pipe_data_i  (pipe_data_i),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_ready_i  (out_ready_i),
        .flush_i      (flush_i),
        .usage_o      (usage_o),
        .error_o      (error_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;

    // two-stage model of the non-stallable payload pipe
    logic          p0_v = 1'b0, p1_v = 1'b0;
    logic [DW-1:0] p0_d = '0, p1_d = '0;

    typedef struct {
        logic          r, iv;
        logic [DW-1:0] d;
        logic          ordy, fl, frc;
        logic          e_rdy, e_val;
        logic [DW-1:0] e_data;
        int            e_use;
        logic          e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input logic r, iv, input logic [DW-1:0] d,
                              input logic ordy, fl, frc,
                              input logic e_rdy, e_val, input logic [DW-1:0] e_data,
                              input int e_use, input logic e_err);
        vec_t t;
        t.r = r; t.iv = iv; t.d = d; t.ordy = ordy; t.fl = fl; t.frc = frc;
        t.e_rdy = e_rdy; t.e_val = e_val; t.e_data = e_data;
        t.e_use = e_use; t.e_err = e_err;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called at a falling edge: applies inputs, clocks once, returns at the
    // next falling edge. The pipe is fed with launches the DUT accepted.
    task automatic step(input logic r, iv, input logic [DW-1:0] d,
                        input logic ordy, fl, frc);
        logic launch;
        rst_i         = r;
        issue_valid_i = iv;
        out_ready_i   = ordy;
        flush_i       = fl;
        pipe_valid_i  = frc | p1_v;
        pipe_data_i   = frc ? d : p1_d;
        launch        = iv & issue_ready_o;
        @(posedge clk_i);
        p1_v = p0_v; p1_d = p0_d;
        p0_v = launch; p0_d = d;
        if (r) begin
            p0_v = 1'b0; p1_v = 1'b0;
        end
        @(negedge clk_i);
    endtask

    // reference model state
    logic [DW-1:0] m_q[$];
    int            m_inflight;
    logic [DW-1:0] m_head;

    initial begin
        // reset held with issue and pipe activity
        v(1,1,32'h11,0,0,1, 1,0,32'h0,0,0);
        v(1,1,32'h22,0,0,1, 1,0,32'h0,0,0);
        // fill: issue A0..A5 every cycle, consumer stalled
        v(0,1,32'hA0,0,0,0, 1,0,32'h0,0,0);
        v(0,1,32'hA1,0,0,0, 1,0,32'h0,0,0);
        v(0,1,32'hA2,0,0,0, 1,1,32'hA0,1,0);
        v(0,1,32'hA3,0,0,0, 0,1,32'hA0,2,0);
        v(0,1,32'hA4,0,0,0, 0,1,32'hA0,3,0);
        v(0,1,32'hA5,0,0,0, 0,1,32'hA0,4,0);
        v(0,0,32'h0 ,0,0,0, 0,1,32'hA0,4,0);
        // drain
        v(0,0,32'h0,1,0,0, 1,1,32'hA1,3,0);
        v(0,0,32'h0,1,0,0, 1,1,32'hA2,2,0);
        v(0,0,32'h0,1,0,0, 1,1,32'hA3,1,0);
        v(0,0,32'h0,1,0,0, 1,0,32'hA3,0,0);
        // second fill across the pointer wrap
        v(0,1,32'hB0,0,0,0, 1,0,32'hA3,0,0);
        v(0,1,32'hB1,0,0,0, 1,0,32'hA3,0,0);
        v(0,1,32'hB2,0,0,0, 1,1,32'hB0,1,0);
        v(0,1,32'hB3,0,0,0, 0,1,32'hB0,2,0);
        v(0,0,32'h0 ,0,0,0, 0,1,32'hB0,3,0);
        v(0,0,32'h0 ,0,0,0, 0,1,32'hB0,4,0);
        v(0,0,32'h0,1,0,0, 1,1,32'hB1,3,0);
        v(0,0,32'h0,1,0,0, 1,1,32'hB2,2,0);
        v(0,0,32'h0,1,0,0, 1,1,32'hB3,1,0);
        v(0,0,32'h0,1,0,0, 1,0,32'hB3,0,0);
        // steady streaming, one word per cycle, usage stays 1
        v(0,1,32'hC0,1,0,0, 1,0,32'hB3,0,0);
        v(0,1,32'hC1,1,0,0, 1,0,32'hB3,0,0);
        v(0,1,32'hC2,1,0,0, 1,1,32'hC0,1,0);
        v(0,1,32'hC3,1,0,0, 1,1,32'hC1,1,0);
        v(0,1,32'hC4,1,0,0, 1,1,32'hC2,1,0);
        v(0,1,32'hC5,1,0,0, 1,1,32'hC3,1,0);
        v(0,0,32'h0 ,1,0,0, 1,1,32'hC4,1,0);
        v(0,0,32'h0 ,1,0,0, 1,1,32'hC5,1,0);
        v(0,0,32'h0 ,1,0,0, 1,0,32'hC5,0,0);
        // flush with 2 stored and 2 in flight (one issued in the flush cycle)
        v(0,1,32'hD0,0,0,0, 1,0,32'hC5,0,0);
        v(0,1,32'hD1,0,0,0, 1,0,32'hC5,0,0);
        v(0,0,32'h0 ,0,0,0, 1,1,32'hD0,1,0);
        v(0,1,32'hD2,0,0,0, 1,1,32'hD0,2,0);
        v(0,1,32'hD3,0,1,0, 1,0,32'hD0,0,0);
        v(0,0,32'h0 ,0,0,0, 1,1,32'hD2,1,0);
        v(0,0,32'h0 ,0,0,0, 1,1,32'hD2,2,0);
        v(0,0,32'h0 ,1,0,0, 1,1,32'hD3,1,0);
        v(0,0,32'h0 ,1,0,0, 1,0,32'hD3,0,0);
        // flush with a same-cycle arrival: arrival is retained
        v(0,1,32'hE0,0,0,0, 1,0,32'hD3,0,0);
        v(0,0,32'h0 ,0,0,0, 1,0,32'hD3,0,0);
        v(0,0,32'h0 ,0,1,0, 1,1,32'hE0,1,0);
        v(0,0,32'h0 ,1,0,0, 1,0,32'hE0,0,0);
        // spurious arrival: sticky error, word dropped, cleared by reset
        v(0,0,32'h55,0,0,1, 1,0,32'hE0,0,1);
        v(0,0,32'h0 ,0,0,0, 1,0,32'hE0,0,1);
        v(0,1,32'h0 ,0,0,0, 1,0,32'hE0,0,1);
        v(1,0,32'h0 ,0,0,0, 1,0,32'h0 ,0,0);

        @(negedge clk_i);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, tbl[i].frc);
            chk($sformatf("vec%0d issue_ready", i), {31'b0, issue_ready_o}, {31'b0, tbl[i].e_rdy});
            chk($sformatf("vec%0d out_valid", i),   {31'b0, out_valid_o},   {31'b0, tbl[i].e_val});
            chk($sformatf("vec%0d out_data", i),    out_data_o,             tbl[i].e_data);
            chk($sformatf("vec%0d usage", i),       DW'(usage_o),           DW'(tbl[i].e_use));
            chk($sformatf("vec%0d error", i),       {31'b0, error_o},       {31'b0, tbl[i].e_err});
        end

        // randomized phase against the reference model
        step(1, 0, '0, 0, 0, 0);
        m_q.delete();
        m_inflight = 0;
        m_head = '0;
        for (int c = 0; c < 1500; c++) begin
            logic          iv, ordy, fl, push, issue, pop, m_rdy;
            logic [DW-1:0] d, pd;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            d    = $urandom;
            push = p1_v;
            pd   = p1_d;
            m_rdy = ((m_inflight + m_q.size()) < DEPTH);
            issue = iv & m_rdy;
            pop   = (m_q.size() != 0) & ordy;
            step(0, iv, d, ordy, fl, 0);
            if (fl) begin
                m_q.delete();
                if (push) m_q.push_back(pd);
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) m_q.push_back(pd);
            end
            m_inflight = m_inflight + int'(issue) - int'(push);
            if (m_q.size() != 0) m_head = m_q[0];
            chk("rnd issue_ready", {31'b0, issue_ready_o},
                {31'b0, ((m_inflight + m_q.size()) < DEPTH) ? 1'b1 : 1'b0});
            chk("rnd out_valid", {31'b0, out_valid_o}, {31'b0, (m_q.size() != 0) ? 1'b1 : 1'b0});
            chk("rnd out_data", out_data_o, m_head);
            chk("rnd usage", DW'(usage_o), DW'(m_q.size()));
            chk("rnd error", {31'b0, error_o}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
